int_to_int_array: RTL and testbench

Four-lane saturating integer precision/signedness converter in the vector datapath. It takes a 128-bit source vector of four 32-bit lanes and a 7-bit micro-instruction from the control unit. Each lane is converted between s32/u32/s16/u16 with saturation. It returns a registered 128-bit result and forwards the micro-instruction alongside it, with one-cycle latency.

---
 rtl/int_to_int_array_pkg.sv | 61 ++++++
 rtl/int_to_int_lane.sv | 40 ++++
 rtl/int_to_int_array.sv | 47 ++++
 tb/tb_int_to_int_array.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/int_to_int_array_pkg.sv
// Shared definitions for the four-lane integer precision/signedness converter:
// micro-instruction bit positions, saturation limits, lane geometry and the
// saturation/extension helpers used by every lane.
package int_to_int_array_pkg;

    // Micro-instruction bit positions
    localparam int VLD        = 6;
    localparam int SRC_PREC   = 5;
    localparam int DST_PREC   = 4;
    localparam int SRC_SIGNED = 3;
    localparam int DST_SIGNED = 2;
    localparam int SRC_POS    = 1;
    localparam int DST_POS    = 0;

    // Lane geometry
    localparam int LANE_W = 32;
    localparam int LANE_N = 4;

    // Saturation limits
    localparam logic [31:0] S32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] S32_MIN = 32'h8000_0000;
    localparam logic [31:0] U32_MAX = 32'hFFFF_FFFF;
    localparam logic [31:0] U32_MIN = 32'h0000_0000;
    localparam logic [15:0] S16_MAX = 16'h7FFF;
    localparam logic [15:0] S16_MIN = 16'h8000;
    localparam logic [15:0] U16_MAX = 16'hFFFF;
    localparam logic [15:0] U16_MIN = 16'h0000;

    // All source values are widened to 33-bit signed so that the full u32
    // range and the full s32 range can be compared against one another.
    function automatic logic signed [32:0] ext32(input logic [31:0] x, input logic s);
        ext32 = {s & x[31], x};
    endfunction

    function automatic logic signed [32:0] ext16(input logic [15:0] x, input logic s);
        ext16 = {{17{s & x[15]}}, x};
    endfunction

    // Clamp a widened value into the s32 or u32 range
    function automatic logic [31:0] sat32(input logic signed [32:0] v, input logic dst_signed);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = dst_signed ? {1'b0, S32_MAX} : {1'b0, U32_MAX};
        lo = dst_signed ? {1'b1, S32_MIN} : {1'b0, U32_MIN};
        if (v > hi)      sat32 = hi[31:0];
        else if (v < lo) sat32 = lo[31:0];
        else             sat32 = v[31:0];
    endfunction

    // Clamp a widened value into the s16 or u16 range
    function automatic logic [15:0] sat16(input logic signed [32:0] v, input logic dst_signed);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = dst_signed ? {17'd0, S16_MAX} : {17'd0, U16_MAX};
        lo = dst_signed ? {{17{1'b1}}, S16_MIN} : {17'd0, U16_MIN};
        if (v > hi)      sat16 = hi[15:0];
        else if (v < lo) sat16 = lo[15:0];
        else             sat16 = v[15:0];
    endfunction

endpackage

// File: rtl/int_to_int_lane.sv
// One 32-bit lane of the converter. Purely combinational: the selected source
// field is widened, saturated into the destination range and placed.
module int_to_int_lane
    import int_to_int_array_pkg::*;
(
    input  logic [LANE_W-1:0] data,
    input  logic              src_prec,
    input  logic              dst_prec,
    input  logic              src_signed,
    input  logic              dst_signed,
    input  logic              src_pos,
    input  logic              dst_pos,
    output logic [LANE_W-1:0] result
);

    logic [15:0] src_half;
    logic [15:0] narrow;

    // Convert according to source/destination precision
    always_comb begin
        result   = '0;
        src_half = src_pos ? data[31:16] : data[15:0];
        narrow   = '0;
        case ({src_prec, dst_prec})
            2'b11: result = sat32(ext32(data, src_signed), dst_signed);
            2'b10: begin
                // The unselected destination half stays zero
                narrow = sat16(ext32(data, src_signed), dst_signed);
                result = dst_pos ? {narrow, 16'h0000} : {16'h0000, narrow};
            end
            2'b01: result = sat32(ext16(src_half, src_signed), dst_signed);
            default: begin
                // 16->16 converts both halves in place
                result = {sat16(ext16(data[31:16], src_signed), dst_signed),
                          sat16(ext16(data[15:0],  src_signed), dst_signed)};
            end
        endcase
    end

endmodule

// File: rtl/int_to_int_array.sv
// Four-lane saturating integer converter with one-cycle latency. The lanes
// share the instruction; the top only holds the result and instruction
// registers so the instruction leaves aligned with its data.
module int_to_int_array
    import int_to_int_array_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] dvr_inttoint_s_in,
    input  logic [6:0]   cru_inttoint_in,
    input  logic [4:0]   smc_id_in,
    output logic [127:0] dr_inttoint_d_out,
    output logic [6:0]   cru_inttoint_out
);

    logic [127:0] lane_vec;
    logic         smc_id_unused;

    // The sub-machine id is reserved and does not steer the datapath
    assign smc_id_unused = ^smc_id_in;

    // Lane 0 sits in the most significant word
    for (genvar i = 0; i < LANE_N; i++) begin : g_lane
        int_to_int_lane u_lane (
            .data       (dvr_inttoint_s_in[(LANE_N-1-i)*LANE_W +: LANE_W]),
            .src_prec   (cru_inttoint_in[SRC_PREC]),
            .dst_prec   (cru_inttoint_in[DST_PREC]),
            .src_signed (cru_inttoint_in[SRC_SIGNED]),
            .dst_signed (cru_inttoint_in[DST_SIGNED]),
            .src_pos    (cru_inttoint_in[SRC_POS]),
            .dst_pos    (cru_inttoint_in[DST_POS]),
            .result     (lane_vec[(LANE_N-1-i)*LANE_W +: LANE_W])
        );
    end

    // Register the converted vector (zero when not valid) and the instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_inttoint_d_out <= '0;
            cru_inttoint_out  <= '0;
        end else begin
            dr_inttoint_d_out <= cru_inttoint_in[VLD] ? lane_vec : '0;
            cru_inttoint_out  <= cru_inttoint_in;
        end
    end

endmodule

// File: tb/tb_int_to_int_array.sv
// Directed bench for int_to_int_array: hand-computed vectors for each
// conversion class, control and reset behaviour, then a run of back-to-back
// random instructions checked against an independent integer model.
module tb_int_to_int_array;

    logic         clk;
    logic         rst_n;
    logic [127:0] dvr_inttoint_s_in;
    logic [6:0]   cru_inttoint_in;
    logic [4:0]   smc_id_in;
    logic [127:0] dr_inttoint_d_out;
    logic [6:0]   cru_inttoint_out;

    int n_vec;
    int n_err;

    int_to_int_array dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dvr_inttoint_s_in (dvr_inttoint_s_in),
        .cru_inttoint_in   (cru_inttoint_in),
        .smc_id_in         (smc_id_in),
        .dr_inttoint_d_out (dr_inttoint_d_out),
        .cru_inttoint_out  (cru_inttoint_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_d(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: data got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_c(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: instr got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction/vector at the falling edge, check after the rising edge
    task automatic step(input string tag, input logic [6:0] ins, input logic [127:0] d,
                        input logic [127:0] exp);
        @(negedge clk);
        cru_inttoint_in   = ins;
        dvr_inttoint_s_in = d;
        smc_id_in         = 5'($urandom_range(0, 31));
        @(posedge clk);
        #1;
        check_d(tag, dr_inttoint_d_out, exp);
        check_c(tag, cru_inttoint_out, ins);
    endtask

    // Independent reference: plain 64-bit integer arithmetic and clamping
    function automatic longint val32(input logic [31:0] x, input bit s);
        if (s) return longint'($signed(x));
        return longint'({32'd0, x});
    endfunction

    function automatic longint val16(input logic [15:0] x, input bit s);
        if (s) return longint'($signed(x));
        return longint'({48'd0, x});
    endfunction

    function automatic longint clampv(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [31:0] ref_lane(input logic [31:0] d, input logic [6:0] ins);
        longint lo, hi, r, r2;
        logic [63:0] a, b;
        logic [15:0] h;
        if (ins[2]) begin
            lo = ins[4] ? -64'sd2147483648 : -64'sd32768;
            hi = ins[4] ? 64'sd2147483647 : 64'sd32767;
        end else begin
            lo = 0;
            hi = ins[4] ? 64'sd4294967295 : 64'sd65535;
        end
        if (ins[5] && ins[4]) begin
            a = clampv(val32(d, ins[3]), lo, hi);
            return a[31:0];
        end else if (ins[5]) begin
            a = clampv(val32(d, ins[3]), lo, hi);
            return ins[0] ? {a[15:0], 16'h0000} : {16'h0000, a[15:0]};
        end else if (ins[4]) begin
            h = ins[1] ? d[31:16] : d[15:0];
            a = clampv(val16(h, ins[3]), lo, hi);
            return a[31:0];
        end
        r  = clampv(val16(d[31:16], ins[3]), lo, hi);
        r2 = clampv(val16(d[15:0], ins[3]), lo, hi);
        a = r;
        b = r2;
        return {a[15:0], b[15:0]};
    endfunction

    function automatic logic [127:0] ref_vec(input logic [127:0] d, input logic [6:0] ins);
        logic [127:0] v;
        v = '0;
        if (ins[6]) begin
            for (int i = 0; i < 4; i++)
                v[i*32 +: 32] = ref_lane(d[i*32 +: 32], ins);
        end
        return v;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] corners [8];
        corners[0] = 32'h7FFF_FFFF; corners[1] = 32'h8000_0000;
        corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h0000_0000;
        corners[4] = 32'h0000_7FFF; corners[5] = 32'hFFFF_8000;
        corners[6] = 32'h8000_7FFF; corners[7] = 32'h7FFF_8000;
        if ($urandom_range(0, 1) == 0) return corners[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    initial begin
        logic [127:0] d;
        logic [6:0]   ins;
        n_vec = 0;
        n_err = 0;

        // Reset
        rst_n             = 1'b0;
        dvr_inttoint_s_in = '0;
        cru_inttoint_in   = '0;
        smc_id_in         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_d("reset_state", dr_inttoint_d_out, '0);
        check_c("reset_state", cru_inttoint_out, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 32 -> 32
        step("s32_s32", 7'h7C, {32'h0000_007F, 32'hFFFF_FF80, 32'h7FFF_FFFF, 32'h8000_0000},
                               {32'h0000_007F, 32'hFFFF_FF80, 32'h7FFF_FFFF, 32'h8000_0000});
        step("s32_u32", 7'h78, {32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0000, 32'hFFFF_FFFF},
                               {32'h0000_007F, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        step("u32_s32", 7'h74, {32'h0000_007F, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF},
                               {32'h0000_007F, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF});
        step("u32_u32", 7'h70, {32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h0000_0001},
                               {32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h0000_0001});

        // 32 -> 16
        step("s32_s16_lo", 7'h6C, {32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF},
                                  {32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_8000, 32'h0000_8000});
        step("s32_s16_hi", 7'h6D, {32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_7FFF},
                                  {32'h7FFF_0000, 32'h7FFF_0000, 32'h8000_0000, 32'h8000_0000});
        step("u32_u16", 7'h60, {32'h0001_2345, 32'h0000_ABCD, 32'hFFFF_FFFF, 32'h0000_0000},
                               {32'h0000_FFFF, 32'h0000_ABCD, 32'h0000_FFFF, 32'h0000_0000});
        step("s32_u16", 7'h68, {32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_1234},
                               {32'h0000_0000, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_1234});

        // 16 -> 32
        step("s16h_u32", 7'h5A, {32'h7FFF_0000, 32'h8000_0000, 32'h007F_0000, 32'hFFFE_0000},
                                {32'h0000_7FFF, 32'h0000_0000, 32'h0000_007F, 32'h0000_0000});
        step("s16l_s32", 7'h5C, {32'h0000_FFFF, 32'h1234_8000, 32'h0000_7FFF, 32'hABCD_0001},
                                {32'hFFFF_FFFF, 32'hFFFF_8000, 32'h0000_7FFF, 32'h0000_0001});
        step("u16l_u32", 7'h50, {32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_8000},
                                {32'h0000_ABCD, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_8000});

        // 16 -> 16
        step("u16_s16", 7'h44, {32'h7FFF_8000, 32'hFFFF_0001, 32'h0000_0000, 32'h1234_5678},
                               {32'h7FFF_7FFF, 32'h7FFF_0001, 32'h0000_0000, 32'h1234_5678});
        step("s16_u16", 7'h48, {32'h0000_FFFF, 32'h7FFF_8000, 32'h0000_0000, 32'h8001_0001},
                               {32'h0000_0000, 32'h7FFF_0000, 32'h0000_0000, 32'h0000_0001});

        // Not valid: data forced to zero, instruction still forwarded
        step("vld0_zero", 7'h00, {32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001}, '0);
        step("vld0_ctrl", 7'h3C, {32'h0000_007F, 32'hFFFF_FF80, 32'h7FFF_FFFF, 32'h8000_0000}, '0);

        // Reset asserted mid-stream clears both outputs asynchronously
        step("pre_reset", 7'h7C, {4{32'h1111_2222}}, {4{32'h1111_2222}});
        @(negedge clk);
        cru_inttoint_in   = 7'h7C;
        dvr_inttoint_s_in = {4{32'h3333_4444}};
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_d("async_reset", dr_inttoint_d_out, '0);
        check_c("async_reset", cru_inttoint_out, '0);
        @(posedge clk);
        #1;
        check_d("held_reset", dr_inttoint_d_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 7'h74, {32'h8000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h7FFF_FFFF},
                                  {32'h7FFF_FFFF, 32'h0000_0005, 32'h7FFF_FFFF, 32'h7FFF_FFFF});

        // Back-to-back random instructions against the reference model
        for (int k = 0; k < 60; k++) begin
            ins = 7'($urandom_range(0, 127));
            if (k % 8 != 7) ins[6] = 1'b1;
            d = {rand_word(), rand_word(), rand_word(), rand_word()};
            step("random", ins, d, ref_vec(d, ins));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
